// File: rtl/alu_exec_pkg.sv
// Shared types and decode for the EX-stage ALU: operation enum, ALUOp/func7
// encodings, FSM states and the ALUOp/func3/func7 decoder.
package alu_exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_PASSB, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } alu_op_e;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_R     = 3'b010;
  localparam logic [2:0] ALUOP_I     = 3'b011;
  localparam logic [2:0] ALUOP_PASSB = 3'b100;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic alu_op_e decode_op(input logic [2:0] aluop, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic en_m);
    alu_op_e base_op;
    alu_op_e op;
    unique case (f3)
      3'd0:    base_op = OP_ADD;
      3'd1:    base_op = OP_SLL;
      3'd2:    base_op = OP_SLT;
      3'd3:    base_op = OP_SLTU;
      3'd4:    base_op = OP_XOR;
      3'd5:    base_op = OP_SRL;
      3'd6:    base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
    op = OP_ILLEGAL;
    unique case (aluop)
      ALUOP_ADD:   op = OP_ADD;
      ALUOP_SUB:   op = OP_SUB;
      ALUOP_PASSB: op = OP_PASSB;
      ALUOP_R: begin
        if (f7 == F7_BASE) op = base_op;
        else if (f7 == F7_ALT && f3 == 3'd0) op = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'd5) op = OP_SRA;
        else if (f7 == F7_MULDIV && en_m) begin
          unique case (f3)
            3'd0:    op = OP_MUL;
            3'd1:    op = OP_MULH;
            3'd2:    op = OP_MULHSU;
            3'd3:    op = OP_MULHU;
            3'd4:    op = OP_DIV;
            3'd5:    op = OP_DIVU;
            3'd6:    op = OP_REM;
            default: op = OP_REMU;
          endcase
        end
      end
      ALUOP_I: begin
        // func7 is immediate bits here except for the shift encodings
        unique case (f3)
          3'd0:    op = OP_ADD;
          3'd1:    op = (f7 == F7_BASE) ? OP_SLL : OP_ILLEGAL;
          3'd5:    op = (f7 == F7_BASE) ? OP_SRL : (f7 == F7_ALT) ? OP_SRA : OP_ILLEGAL;
          default: op = base_op;
        endcase
      end
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  function automatic logic is_muldiv(input alu_op_e op);
    unique case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring divide on operand
// magnitudes, ITER_BITS bits per cycle, sign correction applied on the output.
module muldiv_iter
  import alu_exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / ITER_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic [XLEN-1:0] hi, lo, m, a_orig;
  logic [CW-1:0]   cnt;
  logic            is_div, neg_a, neg_b, b_zero;
  alu_op_e         op_q;

  logic            s_is_div, s_sgn_a, s_sgn_b, s_neg_a, s_neg_b;
  logic [XLEN-1:0] s_mag_a, s_mag_b;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // hi: partial product / remainder, lo: multiplier / quotient
  function automatic logic [2*XLEN-1:0] step(input logic div, input logic [XLEN-1:0] h,
                                             input logic [XLEN-1:0] l, input logic [XLEN-1:0] mm);
    logic [XLEN:0] t;
    logic ge;
    for (int unsigned i = 0; i < ITER_BITS; i++) begin
      if (div) begin
        t  = {h, l[XLEN-1]};
        ge = (t >= {1'b0, mm});
        if (ge) t = t - {1'b0, mm};
        h = t[XLEN-1:0];
        l = {l[XLEN-2:0], ge};
      end else begin
        t = {1'b0, h} + (l[0] ? {1'b0, mm} : '0);
        h = t[XLEN:1];
        l = {t[0], l[XLEN-1:1]};
      end
    end
    return {h, l};
  endfunction

  always_comb begin
    s_is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    s_sgn_a  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s_sgn_b  = op inside {OP_MULH, OP_DIV, OP_REM};
    s_neg_a  = s_sgn_a & a[XLEN-1];
    s_neg_b  = s_sgn_b & b[XLEN-1];
    s_mag_a  = s_neg_a ? -a : a;
    s_mag_b  = s_neg_b ? -b : b;
  end

  // The first step is folded into the load so the last one lands on the done cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      op_q   <= OP_ILLEGAL;
    end else if (start) begin
      {hi, lo} <= step(s_is_div, '0, s_is_div ? s_mag_a : s_mag_b, s_is_div ? s_mag_b : s_mag_a);
      m        <= s_is_div ? s_mag_b : s_mag_a;
      cnt      <= CW'(1);
      a_orig   <= a;
      is_div   <= s_is_div;
      neg_a    <= s_neg_a;
      neg_b    <= s_neg_b;
      b_zero   <= (b == '0);
      op_q     <= op;
    end else if (cnt != '0 && cnt != CW'(STEPS)) begin
      {hi, lo} <= step(is_div, hi, lo, m);
      cnt      <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CW'(STEPS));

  always_comb begin
    prod     = {hi, lo};
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    quo_fix  = (neg_a ^ neg_b) ? -lo : lo;
    rem_fix  = neg_a ? -hi : hi;
    unique case (op_q)
      OP_MUL:                        result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:                        result = b_zero ? '1 : quo_fix;
      OP_DIVU:                       result = b_zero ? '1 : lo;
      OP_REM:                        result = b_zero ? a_orig : rem_fix;
      OP_REMU:                       result = b_zero ? a_orig : hi;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshake: decodes ALUOp/func3/func7, runs base
// ops in one cycle and hands RV32M ops to the iterative mul/div engine.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 1,
  parameter int ENABLE_M  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ALUOp,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  state_e          state;
  alu_op_e         dec;
  logic            dec_m, accept, md_done;
  logic [XLEN-1:0] base_res, md_result;
  logic [SHW-1:0]  shamt;

  assign dec       = decode_op(ALUOp, func3, func7, ENABLE_M != 0);
  assign dec_m     = is_muldiv(dec);
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign shamt     = op_b[SHW-1:0];

  always_comb begin
    base_res = '0;
    unique case (dec)
      OP_ADD:   base_res = op_a + op_b;
      OP_SUB:   base_res = op_a - op_b;
      OP_SLL:   base_res = op_a << shamt;
      OP_SLT:   base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:   base_res = op_a ^ op_b;
      OP_SRL:   base_res = op_a >> shamt;
      OP_SRA:   base_res = $signed(op_a) >>> shamt;
      OP_OR:    base_res = op_a | op_b;
      OP_AND:   base_res = op_a & op_b;
      OP_PASSB: base_res = op_b;
      default:  base_res = '0;
    endcase
  end

  muldiv_iter #(
    .XLEN      (XLEN),
    .ITER_BITS (ITER_BITS)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept & dec_m),
    .op     (dec),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (dec_m) begin
              state <= CALC;
            end else begin
              state   <= DONE;
              result  <= base_res;
              illegal <= (dec == OP_ILLEGAL);
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (md_done) begin
            state   <= DONE;
            result  <= md_result;
            illegal <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal cases, handshake/reset scenarios and
// randomized traffic scored against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [2:0]  ALUOp, func3;
  logic [6:0]  func7;
  logic [31:0] op_a, op_b, result;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(
    .XLEN      (32),
    .ITER_BITS (1),
    .ENABLE_M  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .func3     (func3),
    .func7     (func7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] base_fn(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] mext(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Returns {illegal, result}
  function automatic logic [32:0] model(input logic [2:0] aop, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa = a;
    case (aop)
      3'd0: return {1'b0, a + b};
      3'd1: return {1'b0, a - b};
      3'd4: return {1'b0, b};
      3'd2: begin
        if (f7 == 7'h00) return {1'b0, base_fn(f3, a, b)};
        if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, a - b};
        if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 32'(sa >>> b[4:0])};
        if (f7 == 7'h01) return {1'b0, mext(f3, a, b)};
        return {1'b1, 32'h0};
      end
      3'd3: begin
        if (f3 == 3'd0) return {1'b0, a + b};
        if (f3 == 3'd1) return (f7 == 7'h00) ? {1'b0, a << b[4:0]} : {1'b1, 32'h0};
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return {1'b0, a >> b[4:0]};
          if (f7 == 7'h20) return {1'b0, 32'(sa >>> b[4:0])};
          return {1'b1, 32'h0};
        end
        return {1'b0, base_fn(f3, a, b)};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Scoreboard: one expectation per accept, checked every cycle a result is presented
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result actual=out_valid 1 result=%h required=no pending op", result);
        end else begin
          chk("sb_result", 64'({illegal, result}), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(ALUOp, func3, func7, op_a, op_b));
    end
  end

  task automatic set_op(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
    ALUOp = aop; func3 = f3; func7 = f7; op_a = a; op_b = b;
  endtask

  // Holds the op until accepted; returns #1 after the accepting edge with in_valid low
  task automatic issue(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic rnd_ready);
    int n = 0;
    logic acc = 1'b0;
    set_op(aop, f3, f7, a, b);
    in_valid = 1'b1;
    while (!acc) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      n++;
      if (!acc && n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no accept required=accept within 300 cycles");
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [2:0] aop, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ei, input int elat);
    int lat = 0;
    int nbusy = 0;
    out_ready = 1'b1;
    issue(aop, f3, f7, a, b, 1'b0);
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (out_valid || lat > 100) break;
    end
    chk({name, "_latency"}, 64'(lat), 64'(elat));
    chk({name, "_busy_cycles"}, 64'(nbusy), 64'(elat - 1));
    chk(name, 64'({illegal, result}), 64'({ei, er}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(3'd0, 3'd0, 7'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_illegal", 64'(illegal), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run_one("r_sub",      3'b010, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run_one("i_sra",      3'b011, 3'd5, 7'h20, 32'h8000_0000, 32'h404, 32'hF800_0000, 1'b0, 1);
    run_one("i_srl",      3'b011, 3'd5, 7'h00, 32'h8000_0000, 32'h404, 32'h0800_0000, 1'b0, 1);
    run_one("mulh",       3'b010, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    run_one("mulhu",      3'b010, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    run_one("mulhsu",     3'b010, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
    run_one("mul_neg",    3'b010, 3'd0, 7'h01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_one("div_ovf",    3'b010, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
    run_one("rem_ovf",    3'b010, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    run_one("div_neg",    3'b010, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run_one("rem_neg",    3'b010, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run_one("remu_div0",  3'b010, 3'd7, 7'h01, 32'h1234, 32'd0, 32'h1234, 1'b0, 33);
    run_one("divu_div0",  3'b010, 3'd5, 7'h01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    run_one("div_div0",   3'b010, 3'd4, 7'h01, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    run_one("passb_lui",  3'b100, 3'd3, 7'h55, 32'h1111, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1);
    run_one("slt_neg",    3'b011, 3'd2, 7'h7F, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run_one("sltu_neg",   3'b010, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    run_one("illegal_op", 3'b111, 3'd7, 7'h7F, 32'hDEAD, 32'hBEEF, 32'h0, 1'b1, 1);
    run_one("illegal_f7", 3'b010, 3'd1, 7'h20, 32'hDEAD, 32'hBEEF, 32'h0, 1'b1, 1);
    run_one("islli_bad",  3'b011, 3'd1, 7'h20, 32'd1, 32'd3, 32'h0, 1'b1, 1);

    // Stall in DONE, then accept the next op in the same cycle the result is taken
    out_ready = 1'b0;
    issue(3'b000, 3'd0, 7'd0, 32'd100, 32'd23, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_result", 64'({out_valid, result}), 64'({1'b1, 32'd123}));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_op(3'b000, 3'd0, 7'd0, 32'd1, 32'd2);
    in_valid = 1'b1;
    @(negedge clk);
    chk("same_cycle_accept", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      set_op(3'b000, 3'd0, 7'd0, 32'(i * 3), 32'(i + 1000));
      @(negedge clk);
      chk("b2b_valid", 64'({out_valid, in_ready}), 64'(2'b11));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a divide drops it without a result
    issue(3'b010, 3'd4, 7'h01, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_div_state", 64'({out_valid, busy, in_ready}), 64'(3'b001));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("rst_no_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer back-pressure and idle gaps
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  aop;
      logic [6:0]  f7;
      logic [31:0] a, b;
      int r = $urandom_range(0, 9);
      aop = (r < 4) ? 3'b010 : (r < 7) ? 3'b011 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'd1;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk);
        #1;
      end
      issue(aop, 3'($urandom_range(0, 7)), f7, a, b, 1'b1);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
